// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states and access-size encodings.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Halfwords need an even address, words a 4-byte aligned one; bytes are always aligned.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    return ((size == SZ_HALF) && addrLo[0]) || ((size == SZ_WORD) && (addrLo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 2**DEPTH_LOG2 x 32 word store with byte write enables and registered read.
// Read and write share one enable; rdata shows the word as it was before the same-edge write.
module dmem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0] mem [WORDS];

  // Contents deliberately carry no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (en) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder; define DMEM_ALIGN_CHECK_EN to flag and drop misaligned accesses.
// resp_valid pulses WAIT_CYCLES+1 cycles after accept; stall holds the pipeline from accept until RESP.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        stall,
  output logic        addr_err
);

  state_t      stateQ, stateD;
  logic [3:0]  cntQ, cntD;
  logic [3:0]  weQ;
  logic [1:0]  sizeQ;
  logic [31:0] addrQ, wdataQ;

  logic [3:0]  curWe;
  logic [1:0]  curSize;
  logic [31:0] curAddr, curWdata;
  logic        memEn, misal;
  logic [3:0]  arrWe;
  logic        unusedBits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      weQ    <= '0;
      sizeQ  <= '0;
      addrQ  <= '0;
      wdataQ <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (stateQ == IDLE && req_en) begin
        weQ    <= req_we;
        sizeQ  <= req_size;
        addrQ  <= req_addr;
        wdataQ <= req_wdata;
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    case (stateQ)
      IDLE: begin
        if (req_en) begin
          cntD   = 4'(WAIT_CYCLES);
          stateD = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cntD = cntQ - 4'd1;
        if (cntQ <= 4'd1) stateD = RESP;
      end
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // With zero wait states the array fires on the accept edge, before the request is latched.
  assign curWe    = (stateQ == IDLE) ? req_we    : weQ;
  assign curSize  = (stateQ == IDLE) ? req_size  : sizeQ;
  assign curAddr  = (stateQ == IDLE) ? req_addr  : addrQ;
  assign curWdata = (stateQ == IDLE) ? req_wdata : wdataQ;

  assign memEn = (stateD == RESP) && !rst;

`ifdef DMEM_ALIGN_CHECK_EN
  logic errQ;

  assign misal = isMisaligned(curSize, curAddr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) errQ <= 1'b0;
    else     errQ <= memEn && misal;
  end

  assign addr_err = errQ;
`else
  assign misal    = 1'b0;
  assign addr_err = 1'b0;
`endif

  assign arrWe      = misal ? 4'b0000 : curWe;
  // Upper address bits alias by design; size only matters with the alignment check.
  assign unusedBits = ^{curAddr, curSize};

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) uArray (
    .clk   (clk),
    .rst   (rst),
    .en    (memEn),
    .we    (arrWe),
    .idx   (curAddr[DEPTH_LOG2+1:2]),
    .wdata (curWdata),
    .rdata (rdata)
  );

  assign resp_valid = (stateQ == RESP);
  assign stall      = !rst && (((stateQ == IDLE) && req_en) || (stateQ == WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: instance A uses two wait states, instance B none.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enA, enB;
  logic [3:0]  reqWe;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic [31:0] rdataA, rdataB;
  logic        validA, validB, stallA, stallB, errA, errB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dutA (
    .clk(clk), .rst(rst), .req_en(enA), .req_we(reqWe), .req_size(reqSize),
    .req_addr(reqAddr), .req_wdata(reqWdata), .rdata(rdataA),
    .resp_valid(validA), .stall(stallA), .addr_err(errA)
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dutB (
    .clk(clk), .rst(rst), .req_en(enB), .req_we(reqWe), .req_size(reqSize),
    .req_addr(reqAddr), .req_wdata(reqWdata), .rdata(rdataB),
    .resp_valid(validB), .stall(stallB), .addr_err(errB)
  );

  // One request; returns response data, error flag, latency (0 = timeout) and per-cycle stall bits.
  task automatic access(input bit useB, input logic [3:0] we, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat,
                        output logic [7:0] stallMask);
    stallMask = '0;
    lat = 0;
    @(posedge clk); #1;
    reqWe = we; reqSize = sz; reqAddr = addr; reqWdata = wd;
    if (useB) enB = 1'b1; else enA = 1'b1;
    #1;
    stallMask[0] = useB ? stallB : stallA;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      enA = 1'b0; enB = 1'b0;
      #1;
      if (i < 8) stallMask[i] = useB ? stallB : stallA;
      if (useB ? validB : validA) begin
        lat = i;
        break;
      end
    end
    rd  = useB ? rdataB : rdataA;
    err = useB ? errB : errA;
  endtask

  task automatic test_reset();
    rst = 1'b1; enA = 1'b1; enB = 1'b1;
    reqWe = 4'hF; reqSize = SZ_WORD; reqAddr = 32'h0; reqWdata = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (rdataA !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", rdataA, 32'h0); end
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", validA); end
    checks++; if (stallA !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stallA); end
    checks++; if (errA !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", errA); end
    checks++; if (stallB !== 1'b0) begin errors++; $display("FAIL reset_stallB got=%b exp=0", stallB); end
    rst = 1'b0; enA = 1'b0; enB = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int lat; logic [7:0] sm;
    access(0, 4'hF, SZ_WORD, 32'h10, 32'hDEADBEEF, rd, err, lat, sm);
    checks++; if (lat != 3) begin errors++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++; if (sm !== 8'b0000_0111) begin errors++; $display("FAIL wr_stall_pattern got=%b exp=00000111", sm); end
    @(posedge clk); #2;
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got=%b exp=0", validA); end
    access(0, 4'h0, SZ_WORD, 32'h10, 32'h0, rd, err, lat, sm);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_back got=%h exp=deadbeef", rd); end
    checks++; if (lat != 3) begin errors++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    repeat (3) @(posedge clk); #2;
    checks++; if (rdataA !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold got=%h exp=deadbeef", rdataA); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd; logic err; int lat; logic [7:0] sm;
    access(0, 4'hF, SZ_WORD, 32'h20, 32'h11223344, rd, err, lat, sm);
    access(0, 4'b0100, SZ_BYTE, 32'h22, 32'h00AA0000, rd, err, lat, sm);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL bytemask_prewrite got=%h exp=11223344", rd); end
    access(0, 4'h0, SZ_WORD, 32'h20, 32'h0, rd, err, lat, sm);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL bytemask_merge got=%h exp=11aa3344", rd); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic err; int lat; logic [7:0] sm;
    access(1, 4'hF, SZ_WORD, 32'h8, 32'hCAFEF00D, rd, err, lat, sm);
    checks++; if (lat != 1) begin errors++; $display("FAIL zw_latency got=%0d exp=1", lat); end
    checks++; if (sm !== 8'b0000_0001) begin errors++; $display("FAIL zw_stall_pattern got=%b exp=00000001", sm); end
    // Read with req_en held high into the response cycle.
    @(posedge clk); #1;
    reqWe = 4'h0; reqSize = SZ_WORD; reqAddr = 32'h8; enB = 1'b1;
    #1;
    checks++; if (stallB !== 1'b1) begin errors++; $display("FAIL zw_stall_accept got=%b exp=1", stallB); end
    @(posedge clk); #2;
    checks++; if (validB !== 1'b1) begin errors++; $display("FAIL zw_valid got=%b exp=1", validB); end
    checks++; if (stallB !== 1'b0) begin errors++; $display("FAIL zw_stall_resp got=%b exp=0", stallB); end
    checks++; if (rdataB !== 32'hCAFEF00D) begin errors++; $display("FAIL zw_rdata got=%h exp=cafef00d", rdataB); end
    enB = 1'b0;
    @(posedge clk); #2;
    checks++; if (validB !== 1'b0) begin errors++; $display("FAIL zw_valid_drop got=%b exp=0", validB); end
  endtask

  task automatic test_alias();
    logic [31:0] rd; logic err; int lat; logic [7:0] sm;
    access(0, 4'hF, SZ_WORD, 32'h1004, 32'h5, rd, err, lat, sm);
    access(0, 4'h0, SZ_WORD, 32'h0004, 32'h0, rd, err, lat, sm);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL alias got=%h exp=00000005", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic err; int lat; logic [7:0] sm;
    access(0, 4'hF, SZ_WORD, 32'h30, 32'h7, rd, err, lat, sm);
    @(posedge clk); #1;
    reqWe = 4'hF; reqSize = SZ_WORD; reqAddr = 32'h30; reqWdata = 32'h99; enA = 1'b1;
    @(posedge clk); #1;
    enA = 1'b0;
    #1;
    checks++; if (stallA !== 1'b1) begin errors++; $display("FAIL abort_in_wait got=%b exp=1", stallA); end
    rst = 1'b1;
    #1;
    checks++; if (rdataA !== 32'h0) begin errors++; $display("FAIL abort_rdata got=%h exp=0", rdataA); end
    checks++; if (stallA !== 1'b0) begin errors++; $display("FAIL abort_stall got=%b exp=0", stallA); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL abort_no_resp got=%b exp=0", validA); end
    access(0, 4'h0, SZ_WORD, 32'h30, 32'h0, rd, err, lat, sm);
    checks++; if (lat != 3) begin errors++; $display("FAIL abort_idle_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'h7) begin errors++; $display("FAIL abort_no_write got=%h exp=00000007", rd); end
  endtask

  task automatic test_align();
    logic [31:0] rd; logic err; int lat; logic [7:0] sm;
    logic        expErr;
    logic [31:0] expWord;
`ifdef DMEM_ALIGN_CHECK_EN
    expErr  = 1'b1;
    expWord = 32'h12345678;
`else
    expErr  = 1'b0;
    expWord = 32'hA5A5A5A5;
`endif
    access(0, 4'hF, SZ_WORD, 32'h40, 32'h12345678, rd, err, lat, sm);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL align_ok_err got=%b exp=0", err); end
    access(0, 4'hF, SZ_WORD, 32'h42, 32'hA5A5A5A5, rd, err, lat, sm);
    checks++; if (err !== expErr) begin errors++; $display("FAIL align_err got=%b exp=%b", err, expErr); end
    @(posedge clk); #2;
    checks++; if (errA !== 1'b0) begin errors++; $display("FAIL align_err_clear got=%b exp=0", errA); end
    access(0, 4'h0, SZ_WORD, 32'h40, 32'h0, rd, err, lat, sm);
    checks++; if (rd !== expWord) begin errors++; $display("FAIL align_word got=%h exp=%h", rd, expWord); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_zero_wait();
    test_alias();
    test_reset_abort();
    test_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
